// File: rtl/hazard_pkg.sv
// Shared encodings, FSM state type and default sizes for the pipeline hazard unit.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  localparam int TIMEOUT_DEF = 255;
  localparam int CNT_W_DEF   = 32;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MEMWAIT = 1'b1
  } hz_state_e;

  // Wait counter must be able to hold the value TIMEOUT itself.
  function automatic int wait_cnt_w(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Operand forwarding select for one Execute-stage source register; MEM wins over WB.
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic       i_wr_m,
  input  logic [4:0] i_rd_m,
  input  logic       i_wr_w,
  input  logic [4:0] i_rd_w,
  output logic [1:0] o_fwd
);

  always_comb begin
    o_fwd = FWD_RF;
    if (i_wr_m && (i_rd_m != 5'd0) && (i_rd_m == i_rs)) begin
      o_fwd = FWD_MEM;
    end else if (i_wr_w && (i_rd_w != 5'd0) && (i_rd_w == i_rs)) begin
      o_fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding, load-use/branch/memory stalls and flushes,
// a memory-wait FSM with sticky timeout, and saturating stall/flush counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       rdE,
  input  logic [1:0]       ResultSrcE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [4:0]       rdM,
  input  logic [4:0]       rdW,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             StallW,
  output logic             FlushD,
  output logic             FlushE,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int WAIT_W = wait_cnt_w(TIMEOUT);

  logic [1:0]        w_fwd_a;
  logic [1:0]        w_fwd_b;
  logic              w_mem_stall;
  logic              w_lw_stall;
  logic              w_any_stall;
  logic              w_any_flush;
  hz_state_e         r_state;
  hz_state_e         w_state_nxt;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_inc;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  hazard_fwd_sel u_fwd_a (
    .i_rs   (Rs1E),
    .i_wr_m (RegWriteM),
    .i_rd_m (rdM),
    .i_wr_w (RegWriteW),
    .i_rd_w (rdW),
    .o_fwd  (w_fwd_a)
  );

  hazard_fwd_sel u_fwd_b (
    .i_rs   (Rs2E),
    .i_wr_m (RegWriteM),
    .i_rd_m (rdM),
    .i_wr_w (RegWriteW),
    .i_rd_w (rdW),
    .o_fwd  (w_fwd_b)
  );

  assign w_mem_stall = MemReqM && !MemReadyM;
  assign w_lw_stall  = (ResultSrcE == RESULT_LOAD) && (rdE != 5'd0) &&
                       ((rdE == Rs1D) || (rdE == Rs2D));

  assign ForwardAE = rst ? FWD_RF : w_fwd_a;
  assign ForwardBE = rst ? FWD_RF : w_fwd_b;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:     if (w_mem_stall) w_state_nxt = ST_MEMWAIT;
      ST_MEMWAIT: if (MemReadyM || !MemReqM) w_state_nxt = ST_RUN;
      default:    w_state_nxt = ST_RUN;
    endcase
  end

  // Memory stall is decoded from the live handshake, not the state, so the
  // first waiting cycle already freezes the whole pipe.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    StallW = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (w_mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      StallW = 1'b1;
    end else begin
      if (w_lw_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
      if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  assign w_wait_inc = (r_wait == WAIT_W'(TIMEOUT)) ? r_wait : r_wait + WAIT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait    <= '0;
      r_timeout <= 1'b0;
    end else if ((r_state == ST_RUN) && w_mem_stall) begin
      r_wait <= '0;
    end else if (r_state == ST_MEMWAIT) begin
      r_wait <= w_wait_inc;
      if (w_wait_inc == WAIT_W'(TIMEOUT)) r_timeout <= 1'b1;
    end
  end

  assign w_any_stall = StallF | StallD | StallE | StallM | StallW;
  assign w_any_flush = FlushD | FlushE;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_any_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_any_flush) r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

  assign mem_timeout  = r_timeout;
  assign stall_cycles = r_stall_cnt;
  assign flush_events = r_flush_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with a cycle-level reference model checked every cycle.
module tb_hazard_unit;

  localparam int TO   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, rdE, rdM, rdW;
  logic [1:0]    ResultSrcE;
  logic          RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, StallE, StallM, StallW, FlushD, FlushE;
  logic          mem_timeout;
  logic [CW-1:0] stall_cycles, flush_events;

  hazard_unit #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .rdE(rdE),
    .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .rdM(rdM), .rdW(rdW), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model state: what the registered outputs must be after the next edge.
  bit m_waiting = 0;
  int m_wait_cnt = 0;
  bit m_to = 0;
  int m_sc = 0;
  int m_fc = 0;
  bit chk_en = 0;

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (rst) return 2'b00;
    if (RegWriteM && rdM != 0 && rdM == rs) return 2'b10;
    if (RegWriteW && rdW != 0 && rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Packed as {StallF,StallD,StallE,StallM,StallW,FlushD,FlushE}.
  function automatic logic [6:0] exp_ctl();
    logic [6:0] v;
    logic lw;
    v  = '0;
    lw = (ResultSrcE == 2'b01) && (rdE != 0) && (rdE == Rs1D || rdE == Rs2D);
    if (rst) v = 7'b0000011;
    else if (MemReqM && !MemReadyM) v = 7'b1111100;
    else begin
      if (lw) v = v | 7'b1100001;
      if (PCSrcE) v = v | 7'b0000011;
    end
    return v;
  endfunction

  always @(negedge clk) begin
    logic [6:0] c;
    if (chk_en) begin
      c = exp_ctl();
      check("m_fwdA", ForwardAE, exp_fwd(Rs1E));
      check("m_fwdB", ForwardBE, exp_fwd(Rs2E));
      check("m_ctl", {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE}, c);
      check("m_timeout", mem_timeout, m_to);
      check("m_stall_cycles", stall_cycles, m_sc);
      check("m_flush_events", flush_events, m_fc);
      if (rst) begin
        m_waiting = 0; m_wait_cnt = 0; m_to = 0; m_sc = 0; m_fc = 0;
      end else begin
        if (|c[6:2] && m_sc < CMAX) m_sc++;
        if (|c[1:0] && m_fc < CMAX) m_fc++;
        if (!m_waiting) begin
          if (MemReqM && !MemReadyM) begin
            m_waiting = 1;
            m_wait_cnt = 0;
          end
        end else begin
          m_wait_cnt++;
          if (m_wait_cnt >= TO) m_to = 1;
          if (MemReadyM || !MemReqM) m_waiting = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
    ResultSrcE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
    MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic rst_pulse();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle();
    chk_en = 1;
    tick();
    tick();
    // Reset must dominate forwarding and memory stall.
    MemReqM = 1; RegWriteM = 1; rdM = 5; Rs1E = 5;
    #1;
    check("rst_fwdA", ForwardAE, 2'b00);
    check("rst_ctl", {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE}, 7'b0000011);
    tick();
    rst = 0;
    idle();
    #1;
    check("run_ctl", {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE}, 7'b0);
    check("rst_stall_cycles", stall_cycles, 0);
    check("rst_timeout", mem_timeout, 0);
    tick();

    // Forwarding
    rdM = 5; RegWriteM = 1; rdW = 5; RegWriteW = 1; Rs1E = 5;
    #1 check("fwd_mem_prio", ForwardAE, 2'b10);
    tick();
    rdM = 0; Rs2E = 5;
    #1;
    check("fwd_wb_rd0", ForwardAE, 2'b01);
    check("fwdB_wb", ForwardBE, 2'b01);
    tick();
    rdM = 5; RegWriteM = 0; rdW = 0; RegWriteW = 1; Rs2E = 3;
    #1;
    check("fwd_none", ForwardAE, 2'b00);
    tick();
    rdM = 3; RegWriteM = 1; rdW = 5; Rs1E = 5; Rs2E = 3;
    #1;
    check("fwdB_mem", ForwardBE, 2'b10);
    tick();
    idle();

    // Load-use
    ResultSrcE = 2'b01; rdE = 7; Rs2D = 7;
    #1 check("lw_ctl", {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE}, 7'b1100001);
    tick();
    check("lw_stall_cnt", stall_cycles, 1);
    check("lw_flush_cnt", flush_events, 1);
    rdE = 0;
    #1 check("lw_rd0_ctl", {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE}, 7'b0);
    tick();
    idle();

    // Branch, then branch with load-use
    PCSrcE = 1;
    #1 check("br_ctl", {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE}, 7'b0000011);
    tick();
    PCSrcE = 0;
    #1 check("br_flush_cnt", flush_events, 2);
    tick();
    ResultSrcE = 2'b01; rdE = 7; Rs1D = 7; PCSrcE = 1;
    #1 check("lw_br_ctl", {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE}, 7'b1100011);
    tick();
    idle();
    check("lw_br_stall_cnt", stall_cycles, 2);
    check("lw_br_flush_cnt", flush_events, 3);
    tick();

    // Memory stall overriding a taken branch
    rst_pulse();
    MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      #1 check("mem_ctl", {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE}, 7'b1111100);
      tick();
    end
    check("mem_stall_cnt", stall_cycles, 3);
    check("mem_flush_cnt", flush_events, 0);
    MemReadyM = 1;
    #1 check("mem_rel_ctl", {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE}, 7'b0000011);
    tick();
    check("mem_rel_flush_cnt", flush_events, 1);
    check("mem_no_timeout", mem_timeout, 0);
    idle();
    tick();

    // Timeout after 4 MEMWAIT cycles, sticky afterwards
    rst_pulse();
    MemReqM = 1; MemReadyM = 0;
    repeat (4) tick();
    check("to_before", mem_timeout, 0);
    tick();
    check("to_rise", mem_timeout, 1);
    tick();
    MemReadyM = 1;
    tick();
    check("to_sticky_ready", mem_timeout, 1);
    idle();
    tick();
    check("to_sticky_idle", mem_timeout, 1);
    check("to_stall_cnt", stall_cycles, 6);

    // Stall counter saturation, then reset in the middle of MEMWAIT
    MemReqM = 1; MemReadyM = 0;
    repeat (12) tick();
    check("stall_sat", stall_cycles, CMAX);
    rst = 1;
    #1 check("rst_mw_ctl", {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE}, 7'b0000011);
    tick();
    rst = 0;
    MemReqM = 0;
    #1;
    check("rst_mw_timeout", mem_timeout, 0);
    check("rst_mw_stall_cnt", stall_cycles, 0);
    check("rst_mw_flush_cnt", flush_events, 0);
    tick();
    MemReqM = 1;
    repeat (5) tick();
    check("rst_mw_to_again", mem_timeout, 1);
    idle();
    tick();

    // Flush counter saturation
    PCSrcE = 1;
    repeat (17) tick();
    check("flush_sat", flush_events, CMAX);
    idle();
    tick();

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk is the clock and rst is the reset.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the number of consecutive MEMWAIT cycles after which mem_timeout is raised.
REQ-003 Parameter CNT_W, default 32, SHALL set the width of both performance counters.
REQ-004 The block SHALL have these ports, clock and reset first:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- Rs1D, Rs2D  in  5  source registers in Decode
- Rs1E, Rs2E, rdE  in  5  source and destination registers in Execute
- ResultSrcE  in  2  result select in Execute; 2'b01 = load
- RegWriteM, RegWriteW  in  1  write enables in Memory and Writeback
- rdM, rdW  in  5  destination registers in Memory and Writeback
- PCSrcE  in  1  branch taken or jump in Execute
- MemReqM  in  1  load or store in Memory
- MemReadyM  in  1  data memory acknowledge
- ForwardAE, ForwardBE  out  2  operand forwarding select: 00 = RF, 01 = WB, 10 = MEM
- StallF, StallD, StallE, StallM, StallW  out  1  per-stage hold
- FlushD, FlushE  out  1  bubble into the IF/ID and ID/EX registers
- mem_timeout  out  1  sticky error flag
- stall_cycles, flush_events  out  CNT_W  performance counters

Function
REQ-005 ForwardAE SHALL be 10 if RegWriteM, rdM != 0 and rdM == Rs1E; else 01 if RegWriteW, rdW != 0 and rdW == Rs1E; else 00. MEM takes priority when both match.
REQ-006 ForwardBE SHALL use the same rule as REQ-005, with Rs2E in place of Rs1E.
REQ-007 lwStall SHALL be ResultSrcE == 01, rdE != 0, and (rdE == Rs1D or rdE == Rs2D).
REQ-008 memStall SHALL be MemReqM && !MemReadyM, and SHALL be evaluated combinationally in every state.
REQ-009 When memStall is 1, StallF, StallD, StallE, StallM and StallW SHALL all be 1, and FlushD and FlushE SHALL be 0. memStall overrides lwStall and PCSrcE.
REQ-010 When memStall is 0 and lwStall is 1, StallF = StallD = 1, FlushE = 1, and all other stalls SHALL be 0.
REQ-011 When memStall is 0 and PCSrcE is 1, FlushD = 1 and FlushE = 1.
REQ-012 When lwStall and PCSrcE are both 1, FlushD SHALL be 1 and the REQ-010 stalls SHALL still apply.
REQ-013 The FSM SHALL have two states, RUN and MEMWAIT.
- RUN to MEMWAIT when memStall is 1.
- MEMWAIT to RUN when MemReadyM is 1 or MemReqM is 0.
- All other cases hold the current state.
REQ-014 A wait counter SHALL clear on entry to MEMWAIT and increment each MEMWAIT cycle.
REQ-015 When the wait counter reaches TIMEOUT, mem_timeout SHALL be set. The flag is sticky until rst, and the FSM still waits for MemReadyM.
REQ-016 stall_cycles SHALL increment on every cycle in which any Stall output is 1, and SHALL saturate at all-ones.
REQ-017 flush_events SHALL increment on every cycle in which FlushD or FlushE is 1, and SHALL saturate at all-ones.
REQ-018 Forwarding and stall/flush outputs SHALL be combinational, with zero latency. The FSM, wait counter, flag and performance counters SHALL be registered.

Reset
REQ-019 While rst is 1:
- FlushD = FlushE = 1.
- All Stall outputs = 0 and ForwardAE = ForwardBE = 00.
- This overrides all other rules.
REQ-020 On a clk edge with rst = 1:
- The state SHALL become RUN.
- The wait counter, mem_timeout, stall_cycles and flush_events SHALL become 0.
- This applies mid-MEMWAIT as well.

Structure
REQ-021 Package hazard_pkg SHALL hold:
- the forwarding encodings 00/01/10
- the load ResultSrc code 2'b01
- the RUN/MEMWAIT state type
- the default counter widths
REQ-022 Sub-module hazard_fwd_sel SHALL implement REQ-005 for one operand and SHALL be instantiated twice.

Verification
REQ-023 rdM = 5, RegWriteM = 1, rdW = 5, RegWriteW = 1, Rs1E = 5 -> ForwardAE = 10. Same case with rdM = 0 -> ForwardAE = 01.
REQ-024 ResultSrcE = 01, rdE = 7, Rs2D = 7 -> StallF = StallD = 1, FlushE = 1. Same case with rdE = 0 -> no stall.
REQ-025 PCSrcE = 1 for one cycle -> FlushD = FlushE = 1 for that cycle, and flush_events increments by 1.
REQ-026 MemReqM = 1 and MemReadyM = 0 for 3 cycles together with PCSrcE = 1 -> all five stalls = 1 and flushes = 0 for 3 cycles. stall_cycles SHALL equal 3, and after MemReadyM = 1 both flushes SHALL be 1.
REQ-027 TIMEOUT = 4, MemReadyM held at 0 for 6 cycles -> mem_timeout SHALL rise after 4 MEMWAIT cycles and stay 1 after MemReadyM = 1.
REQ-028 rst asserted in MEMWAIT -> next cycle the state is RUN, counters and flag are 0, and FlushD = FlushE = 1 while rst is 1.
